// File: rtl/sum_capture_fifo_pkg.sv
// Shared sizing constants and helpers for the sum capture FIFO.
package sum_capture_fifo_pkg;

    localparam int OWL_DEF   = 5;
    localparam int DEPTH_DEF = 4;

    // Pointer width for a power-of-two depth.
    function automatic int calc_aw(input int depth);
        int aw;
        aw = 0;
        while ((1 << aw) < depth) begin
            aw++;
        end
        return aw;
    endfunction

    localparam int AW_DEF    = calc_aw(DEPTH_DEF);

    // Carry-out position within a default-width captured sum.
    localparam int CARRY_BIT = OWL_DEF - 1;

endpackage

// File: rtl/sum_fifo_ctrl.sv
// Pointer, occupancy and handshake qualification for the sum capture FIFO.
module sum_fifo_ctrl
    import sum_capture_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] L_DEPTH = (AW + 1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Status comes only from the registered count, so in_ready never
    // depends combinationally on out_ready and a full FIFO cannot write through.
    assign full      = (r_count == L_DEPTH);
    assign empty     = (r_count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_ptr    = r_wr_ptr;
    assign rd_ptr    = r_rd_ptr;
    assign count     = r_count;

    // Advance pointers on each transfer; count tracks push minus pop.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (pop && !push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sum_capture_fifo.sv
// Captures adder sums into a small first-word-fall-through buffer and
// tracks whether any captured sum carried out.
module sum_capture_fifo
    import sum_capture_fifo_pkg::*;
#(
    parameter int OWL   = OWL_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OWL-1:0] in_sum,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OWL-1:0] out_sum,
    output logic [AW:0]    count,
    output logic           full,
    output logic           empty,
    output logic           carry_seen,
    input  logic           clr_carry
);

    localparam int L_CARRY_BIT = OWL - 1;

    logic           w_push;
    logic           w_pop;
    logic           w_empty;
    logic [AW-1:0]  w_wr_ptr;
    logic [AW-1:0]  w_rd_ptr;
    logic [OWL-1:0] r_mem [DEPTH];
    logic           r_carry_seen;

    sum_fifo_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (w_push),
        .pop       (w_pop),
        .wr_ptr    (w_wr_ptr),
        .rd_ptr    (w_rd_ptr),
        .count     (count),
        .full      (full),
        .empty     (w_empty)
    );

    assign empty      = w_empty;
    assign carry_seen = r_carry_seen;

    // Write accepted sums into storage.
    // NOTE: storage has no reset; stale words are masked by the empty check on the read side.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= in_sum;
        end
    end

    // Present the head entry, forcing zero when nothing is stored.
    // NOTE: the default assignment first keeps this purely combinational (no latch).
    always_comb begin
        out_sum = '0;
        if (!w_empty) begin
            out_sum = r_mem[w_rd_ptr];
        end
    end

    // Sticky carry flag; a carrying push in the same cycle overrides a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry_seen <= 1'b0;
        end else if (w_push && in_sum[L_CARRY_BIT]) begin
            r_carry_seen <= 1'b1;
        end else if (clr_carry) begin
            r_carry_seen <= 1'b0;
        end
    end

    // w_pop is consumed inside the controller; kept here for readability of the handshake.
    logic w_unused;
    assign w_unused = w_pop;

endmodule

// File: tb/tb_sum_capture_fifo.sv
// Self-checking bench: queue-based reference model plus a pop-side scoreboard monitor.
module tb_sum_capture_fifo;

    localparam int OWL   = 5;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [OWL-1:0] in_sum;
    logic           out_valid;
    logic           out_ready;
    logic [OWL-1:0] out_sum;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    logic           carry_seen;
    logic           clr_carry;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [OWL-1:0] exp_q[$];
    int             m_count   = 0;
    bit             m_carry   = 1'b0;
    bit             m_stalled = 1'b0;

    always #5 clk = ~clk;

    sum_capture_fifo #(
        .OWL   (OWL),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .carry_seen (carry_seen),
        .clr_carry  (clr_carry)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: check status against the abstract FIFO, then apply this edge's transfer.
    always @(negedge clk) begin
        bit acc;
        bit pp;
        if (rst_n) begin
            check("count", 32'(count), 32'(m_count));
            check("full", 32'(full), 32'(m_count == DEPTH));
            check("empty", 32'(empty), 32'(m_count == 0));
            check("in_ready", 32'(in_ready), 32'(m_count < DEPTH));
            check("out_valid", 32'(out_valid), 32'(m_count > 0));
            check("carry_seen", 32'(carry_seen), 32'(m_carry));
            if (m_count == 0) begin
                check("out_sum_empty", 32'(out_sum), 32'd0);
            end
            acc       = in_valid && (m_count < DEPTH);
            pp        = out_ready && (m_count > 0);
            m_stalled = in_valid && !acc;
            if (acc) begin
                exp_q.push_back(in_sum);
            end
            m_count = m_count + int'(acc) - int'(pp);
            if (acc && in_sum[OWL-1]) begin
                m_carry = 1'b1;
            end else if (clr_carry) begin
                m_carry = 1'b0;
            end
        end
    end

    // Scoreboard monitor: compare the head entry whenever the consumer takes it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(out_valid), 32'd0);
            end else begin
                check("out_sum", 32'(out_sum), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic drive(input bit iv, input logic [OWL-1:0] d, input bit ordy, input bit clr);
        in_valid  = iv;
        in_sum    = d;
        out_ready = ordy;
        clr_carry = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        clr_carry = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_carry", 32'(carry_seen), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three pushes, consumer idle
        drive(1'b1, 5'h03, 1'b0, 1'b0);
        drive(1'b1, 5'h0F, 1'b0, 1'b0);
        drive(1'b1, 5'h1E, 1'b0, 1'b0);
        check("t1_count", 32'(count), 32'd3);
        check("t1_head", 32'(out_sum), 32'h03);
        check("t1_carry", 32'(carry_seen), 32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        check("t1_full", 32'(full), 32'd0);
        drain(3);

        // Fill, stall a fifth push, free one slot, then accept it
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, OWL'(i), 1'b0, 1'b0);
        end
        check("t2_full", 32'(full), 32'd1);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 5'h05, 1'b0, 1'b0);
        drive(1'b1, 5'h05, 1'b0, 1'b0);
        check("t2_stalled_count", 32'(count), 32'd4);
        drive(1'b1, 5'h05, 1'b1, 1'b0);
        check("t2_after_pop_count", 32'(count), 32'd3);
        check("t2_after_pop_head", 32'(out_sum), 32'h02);
        drive(1'b1, 5'h05, 1'b0, 1'b0);
        check("t2_refill_count", 32'(count), 32'd4);
        drain(5);
        check("t2_drained", 32'(empty), 32'd1);

        // Steady stream across two pointer wraps
        drive(1'b1, 5'h1F, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, OWL'(i), 1'b1, 1'b0);
            check("t3_count", 32'(count), 32'd1);
            check("t3_head", 32'(out_sum), 32'(i));
        end
        drain(1);

        // Set beats clear, then clear takes effect
        drive(1'b1, 5'h10, 1'b0, 1'b1);
        check("t4_set_wins", 32'(carry_seen), 32'd1);
        drive(1'b1, 5'h0A, 1'b0, 1'b1);
        check("t4_cleared", 32'(carry_seen), 32'd0);
        drain(2);

        // Mid-cycle reset with three entries stored
        drive(1'b1, 5'h11, 1'b0, 1'b0);
        drive(1'b1, 5'h12, 1'b0, 1'b0);
        drive(1'b1, 5'h13, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_out_sum", 32'(out_sum), 32'd0);
        exp_q.delete();
        m_count = 0;
        m_carry = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(1'b1, 5'h07, 1'b0, 1'b0);
        check("t5_first_after_rst", 32'(out_sum), 32'h07);
        drain(1);

        // Pop while empty, push while full
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            check("t6_empty_count", 32'(count), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OWL'(5'h08 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'h15, 1'b0, 1'b0);
            check("t6_full_count", 32'(count), 32'd4);
            check("t6_full_head", 32'(out_sum), 32'h08);
        end
        drain(5);

        // Random traffic; a stalled producer keeps its word stable
        for (int i = 0; i < 400; i++) begin
            if (m_stalled) begin
                drive(1'b1, in_sum, ($urandom % 3) != 0, ($urandom % 8) == 0);
            end else begin
                drive(($urandom % 4) != 0, OWL'($urandom), ($urandom % 3) != 0,
                      ($urandom % 8) == 0);
            end
        end
        drain(DEPTH + 1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sum_capture_fifo.md
Name: sum_capture_fifo

Overview:
Downstream stage of the 4-bit ripple-carry adder. Captures each OWL-bit sum, including the carry-out MSB, through a valid/ready handshake. Holds up to DEPTH results in first-word-fall-through order for the consumer. Keeps a sticky flag that records whether any captured sum carried out.

Parameters:
OWL, 5, width of one captured sum (adder IWL+1; MSB is carry-out)
DEPTH, 4, number of buffered entries; must be a power of two, at least 2
AW, 2, pointer width = log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer presents a sum on in_sum
in_ready  output  1  buffer can accept this cycle
in_sum  input  OWL  sum from adder (s[OWL-1] = cout)
out_valid  output  1  head entry available
out_ready  input  1  consumer takes head entry this cycle
out_sum  output  OWL  head entry; 0 when empty
count  output  AW+1  number of stored entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
carry_seen  output  1  sticky: some pushed sum had MSB set
clr_carry  input  1  synchronous clear of carry_seen

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, carry_seen=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_sum=0, full=0, empty=1.
  - Storage array is not reset.
- Push: occurs when in_valid && in_ready. Writes in_sum at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr increments mod DEPTH.
- in_ready = !full.
  - No write-through when full, even if a pop happens the same cycle. Such a push is stalled.
  - in_ready must not depend combinationally on out_ready.
- out_valid = !empty. out_sum = mem[rd_ptr] when !empty, else 0.
- Latency: a sum pushed at edge N appears as out_valid/out_sum after edge N. This is one cycle; there is no empty-bypass path.
- count updates:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance.
- full and empty derive from registered count. They are never both 1.
- Wrap-around: pointers are AW bits and wrap naturally. Order is strictly FIFO across the wrap.
- Handshake rules:
  - The producer holds in_sum stable while in_valid && !in_ready.
  - The block holds out_sum stable while out_valid && !out_ready.
  - in_valid asserted when full is legal and simply stalls.
  - out_ready asserted when empty is legal and has no effect.
- carry_seen:
  - Set at the edge of any push where in_sum[OWL-1]=1.
  - clr_carry clears it at the edge.
  - If set and clear happen in the same cycle, set wins (result 1).
- Reset mid-operation: all stored entries are discarded immediately and count becomes 0. Data from before reset must never appear on out_sum afterwards.
- No X on any output after reset, regardless of storage contents.

Decomposition:
- Shared package holds:
  - default OWL=5, DEPTH=4, AW=2
  - a function computing AW from DEPTH
  - constant CARRY_BIT = OWL-1
- One natural sub-module: sum_fifo_ctrl.
  - Contents: pointers, count, full/empty, push/pop qualification.
  - The top level holds the storage array, output muxing and carry_seen.

Test Plan:
- Reset, then push 5'h03, 5'h0F, 5'h1E (carry set) with out_ready=0 → count=3, out_sum=5'h03, carry_seen=1 after the third push; empty=0, full=0.
- Push 4 entries 5'h01..5'h04 → full=1, in_ready=0. A fifth push of 5'h05 with out_ready=0 is stalled, count stays 4. Raise out_ready for one cycle → 5'h01 popped; the next cycle 5'h05 is accepted. Drain order must be 01,02,03,04,05.
- Steady stream with in_valid=out_ready=1 for 12 cycles on data 0..11 after one prefill → count constant at 1, outputs in order across two pointer wraps.
- With carry_seen=1, assert clr_carry together with a push of 5'h10 → carry_seen stays 1. Next cycle clr_carry with push 5'h0A → carry_seen=0.
- With 3 entries stored, pulse rst_n low mid-cycle → out_valid=0, count=0, out_sum=0 immediately. After release, push 5'h07 → first pop yields 5'h07.
- out_ready=1 while empty, and in_valid=1 while full, for several cycles → no count/pointer change, no spurious output.
